motor_run_sequencer: RTL
========================

# motor_run_sequencer

Run-state sequencer for the BLDC velocity loop. It sequences motor start-up: rotor alignment with forced commutation, encoder zeroing, settle, then closed-loop run. It schedules the periodic IIR-filter and PI-controller enable pulses and detects stalls. It sits between the top-level run command and the encoder, filter, controller and commutation datapath, and drives all of their sequencing strobes.

## Interface

Parameters:
- ALIGN_CYCLES, 50000: clocks spent in forced-commutation alignment.
- SETTLE_CYCLES, 1000: clocks between encoder zeroing and closed-loop run.
- FILTER_DIV, 500: clock period of filter_pulse (≥2).
- LOOP_RATIO, 10: filter pulses per control_loop_pulse (≥1).
- STALL_TICKS, 1023: time_per_tick above this counts as "not moving".
- STALL_LOOPS, 100: consecutive stalled control periods that trigger a fault.

Ports:
- clk, input, 1: system clock; the only clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: run request, level-sensitive.
- fault_clear, input, 1: acknowledge a fault; level, sampled each clock.
- desired_velocity, input, 16 signed: commanded velocity.
- time_per_tick, input, 32 unsigned: current tick timer measurement.
- reset_encoder_count, output, 1: one-cycle strobe that zeroes the encoder count.
- apply_initial_commutation, output, 1: forced alignment vector request.
- controller_override, output, 1: selects fixed gain instead of PI output.
- commutation_enable, output, 1: enables PWM commutation.
- filter_pulse, output, 1: one-cycle IIR filter update strobe.
- control_loop_pulse, output, 1: one-cycle PI update strobe.
- fault, output, 1: stall fault latched.
- state, output, 3: current FSM state encoding, for diagnostics.

## Operation

State encodings:
- IDLE = 0, ALIGN = 1, ZERO = 2, SETTLE = 3, RUN = 4, FAULT = 5.
- All outputs are registered.

IDLE:
- All strobes and levels are 0.
- On enable = 1, go to ALIGN and clear the cycle counter.

ALIGN:
- apply_initial_commutation = 1, controller_override = 1, commutation_enable = 1.
- After ALIGN_CYCLES clocks in ALIGN, go to ZERO.

ZERO:
- Lasts exactly 1 cycle.
- reset_encoder_count = 1 and commutation_enable = 1; controller_override stays 0.
- Next state is SETTLE.

SETTLE:
- commutation_enable = 1; the filter scheduler runs; control_loop_pulse is suppressed.
- After SETTLE_CYCLES clocks, go to RUN.

RUN:
- commutation_enable = 1; the filter and loop schedulers run.
- The stall monitor is active.

FAULT:
- fault = 1; every other output is 0; the schedulers are held cleared.
- Exit to IDLE only when fault_clear = 1 and enable = 0 in the same cycle.

enable deasserted:
- In ALIGN, ZERO, SETTLE or RUN, dropping enable goes to IDLE on the next clock.
- Counters clear; the stall count clears.
- This exit takes priority over any same-cycle timeout transition.

Scheduler:
- A prescaler counts 0..FILTER_DIV-1 while in SETTLE or RUN and is cleared otherwise.
- filter_pulse = 1 for the cycle after the prescaler wraps.
- A ratio counter counts filter pulses 0..LOOP_RATIO-1.
- In RUN, control_loop_pulse asserts exactly 1 cycle after each filter_pulse that wraps the ratio counter, so the filter output settles before the PI update.
- The ratio counter also advances in SETTLE; the control pulse there is masked.

Stall monitor:
- Evaluated only at each control_loop_pulse in RUN.
- If desired_velocity ≠ 0 and time_per_tick > STALL_TICKS, the stall count increments (saturating); otherwise it clears to 0.
- When the count reaches STALL_LOOPS, the next state is FAULT.
- fault stays latched until IDLE is re-entered.

## Timing

- Reset: state = IDLE (0); every output is 0; all counters are 0.
- reset dominates every other input.
- enable to ALIGN: apply_initial_commutation rises 1 clock after enable is sampled high.
- ALIGN lasts exactly ALIGN_CYCLES clocks.
- ZERO lasts exactly 1 clock.
- SETTLE lasts exactly SETTLE_CYCLES clocks.
- First filter_pulse: FILTER_DIV clocks after SETTLE entry.
- Every strobe is exactly 1 cycle wide; filter_pulse and control_loop_pulse are never high together.
- In steady RUN, control_loop_pulse period = FILTER_DIV × LOOP_RATIO clocks.
- Counter widths are sized by $clog2 of their parameters; the 32-bit comparison against STALL_TICKS is unsigned.
- Fault entry: the cycle after the STALL_LOOPS-th consecutive stalled evaluation.
- fault_clear while enable = 1 is ignored; the block stays in FAULT.

## Test plan

All scenarios use ALIGN_CYCLES = 8, SETTLE_CYCLES = 4, FILTER_DIV = 5, LOOP_RATIO = 2, STALL_TICKS = 1023, STALL_LOOPS = 3.

1. Reset, then enable = 1:
   - ALIGN flags are high for exactly 8 cycles.
   - reset_encoder_count is high for exactly 1 cycle.
   - SETTLE lasts 4 cycles.
   - state then reads 4.
2. RUN with desired_velocity = 100, time_per_tick = 50:
   - filter_pulse every 5 clocks.
   - control_loop_pulse every 10 clocks, each 1 cycle after a filter_pulse.
   - fault stays 0 indefinitely.
3. RUN with desired_velocity = 100, time_per_tick = 2000:
   - After the 3rd control_loop_pulse, state = 5 and fault = 1.
   - All other outputs are 0.
4. In FAULT:
   - fault_clear = 1 with enable = 1: remains in FAULT.
   - Then enable = 0, fault_clear = 1: next state IDLE, fault = 0.
5. Stall-count clearing:
   - Two stalled loops (time_per_tick = 2000), then one loop with time_per_tick = 50, then two stalled loops: no fault.
   - desired_velocity = 0 with time_per_tick = 5000 for 10 loops: no fault.
6. Aborts and reset:
   - enable dropped mid-ALIGN on the cycle its counter expires: next state IDLE, not ZERO.
   - reset asserted mid-RUN: all outputs are 0 on the next clock.

Source files
------------

// File: rtl/motor_run_sequencer.sv
// Start-up and run-state sequencer for the BLDC velocity loop: align, zero, settle, run,
// plus filter/PI strobe scheduling and stall-fault detection.
module motor_run_sequencer #(
    parameter int unsigned ALIGN_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned FILTER_DIV    = 500,
    parameter int unsigned LOOP_RATIO    = 10,
    parameter int unsigned STALL_TICKS   = 1023,
    parameter int unsigned STALL_LOOPS   = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               fault_clear,
    input  logic signed [15:0] desired_velocity,
    input  logic        [31:0] time_per_tick,
    output logic               reset_encoder_count,
    output logic               apply_initial_commutation,
    output logic               controller_override,
    output logic               commutation_enable,
    output logic               filter_pulse,
    output logic               control_loop_pulse,
    output logic               fault,
    output logic        [2:0]  state
);

    localparam int unsigned PHASE_MAX = (ALIGN_CYCLES > SETTLE_CYCLES) ? ALIGN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
    localparam int unsigned PRE_W     = $clog2(FILTER_DIV);
    localparam int unsigned RAT_W     = $clog2(LOOP_RATIO + 1);
    localparam int unsigned STL_W     = $clog2(STALL_LOOPS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ZERO   = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [RAT_W-1:0]   ratio_q, ratio_d;
    logic [STL_W-1:0]   stall_q, stall_d;
    logic [STL_W-1:0]   stall_inc;
    logic               loop_pend_q, loop_pend_d;
    logic               rec_q, rec_d;
    logic               aic_q, aic_d;
    logic               ovr_q, ovr_d;
    logic               cen_q, cen_d;
    logic               fp_q, fp_d;
    logic               clp_q, clp_d;
    logic               fault_q, fault_d;
    logic               active_q, active_d;
    logic               wrap;
    logic               stalled;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            presc_q     <= '0;
            ratio_q     <= '0;
            stall_q     <= '0;
            loop_pend_q <= 1'b0;
            rec_q       <= 1'b0;
            aic_q       <= 1'b0;
            ovr_q       <= 1'b0;
            cen_q       <= 1'b0;
            fp_q        <= 1'b0;
            clp_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            ratio_q     <= ratio_d;
            stall_q     <= stall_d;
            loop_pend_q <= loop_pend_d;
            rec_q       <= rec_d;
            aic_q       <= aic_d;
            ovr_q       <= ovr_d;
            cen_q       <= cen_d;
            fp_q        <= fp_d;
            clp_q       <= clp_d;
            fault_q     <= fault_d;
        end
    end

    // Next state, phase counter and stall monitor
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        stalled   = (desired_velocity != 16'sd0) && (time_per_tick > 32'(STALL_TICKS));
        stall_inc = (stall_q == STL_W'(STALL_LOOPS)) ? stall_q : stall_q + STL_W'(1);

        case (state_q)
            IDLE: begin
                if (enable) state_d = ALIGN;
            end
            ALIGN: begin
                if (cnt_q == CNT_W'(ALIGN_CYCLES - 1)) state_d = ZERO;
                else                                    cnt_d   = cnt_q + CNT_W'(1);
            end
            ZERO: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = RUN;
                else                                     cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: begin
                // Evaluated once per control period, on the visible PI strobe
                if (clp_q) begin
                    if (stalled) begin
                        stall_d = stall_inc;
                        if (stall_inc == STL_W'(STALL_LOOPS)) state_d = FAULT;
                    end else begin
                        stall_d = '0;
                    end
                end
            end
            FAULT: begin
                if (fault_clear && !enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Dropping the run request wins over any same-cycle timeout
        if (!enable && (state_q == ALIGN || state_q == ZERO || state_q == SETTLE || state_q == RUN)) begin
            state_d = IDLE;
        end
        if (state_d != state_q) cnt_d   = '0;
        if (state_d != RUN)     stall_d = '0;
    end

    // Filter/loop scheduler and output decode aligned with the next state
    always_comb begin
        active_q    = (state_q == SETTLE) || (state_q == RUN);
        active_d    = (state_d == SETTLE) || (state_d == RUN);
        wrap        = active_q && (presc_q == PRE_W'(FILTER_DIV - 1));
        presc_d     = '0;
        ratio_d     = '0;
        if (active_q && active_d) begin
            presc_d = wrap ? '0 : presc_q + PRE_W'(1);
            ratio_d = ratio_q;
            if (wrap) ratio_d = (ratio_q == RAT_W'(LOOP_RATIO - 1)) ? '0 : ratio_q + RAT_W'(1);
        end
        loop_pend_d = active_d && wrap && (ratio_q == RAT_W'(LOOP_RATIO - 1));

        rec_d   = (state_d == ZERO);
        aic_d   = (state_d == ALIGN);
        ovr_d   = (state_d == ALIGN);
        cen_d   = (state_d == ALIGN) || (state_d == ZERO) || active_d;
        fp_d    = wrap && active_d;
        clp_d   = loop_pend_q && (state_d == RUN);
        fault_d = (state_d == FAULT);
    end

    assign reset_encoder_count       = rec_q;
    assign apply_initial_commutation = aic_q;
    assign controller_override       = ovr_q;
    assign commutation_enable        = cen_q;
    assign filter_pulse              = fp_q;
    assign control_loop_pulse        = clp_q;
    assign fault                     = fault_q;
    assign state                     = 3'(state_q);

endmodule
